// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared types, opcode constants and immediate helper for the
//               registered ALU control decoder (alu_ctrl_pipe).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

  // Struct fields are sized for the widest datapath; narrower builds use the
  // low XLEN bits.
  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1101,
    ALU_NONE  = 4'b1111
  } alu_op_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    alu_op_t               alu_op;
    logic                  b_imm;
    logic                  a_pc;
    logic [XLEN_MAX-1:0]   imm;
    logic                  illegal;
    logic [XLEN_MAX-1:0]   pc;
    logic                  md_sel;
    logic [2:0]            md_op;
  } dec_t;

  // Base ALU operation selected by funct3 when funct7 is all zeros.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3);
    alu_op_t r;
    case (f3)
      3'b000:  r = ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Sign-extended immediate for the given encoding format.
  function automatic logic [XLEN_MAX-1:0] imm_gen(input logic [31:0] inst,
                                                  input imm_fmt_t    fmt);
    logic [XLEN_MAX-1:0] r;
    case (fmt)
      IMM_I:   r = {{52{inst[31]}}, inst[31:20]};
      IMM_S:   r = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   r = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   r = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:   r = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_dec
// Description : Combinational RV instruction decoder: inst/pc -> dec_t.
//               Define MEXT_EN to accept OP with funct7=0000001 (mul/div).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output dec_t            dec_o
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_sh_zero;
  logic       w_sh_sra;
  alu_op_t    w_op;
  imm_fmt_t   w_fmt;
  logic       w_bimm;
  logic       w_apc;
  logic       w_ill;
  logic       w_md;

  assign w_opc = inst_i[6:0];
  assign w_f3  = inst_i[14:12];
  assign w_f7  = inst_i[31:25];

  // RV64 shift immediates use a 6-bit shamt, so only funct6 qualifies them.
  generate
    if (XLEN == 64) begin : g_shamt6
      assign w_sh_zero = (inst_i[31:26] == 6'b000000);
      assign w_sh_sra  = (inst_i[31:26] == 6'b010000);
    end else begin : g_shamt5
      assign w_sh_zero = (inst_i[31:25] == 7'b0000000);
      assign w_sh_sra  = (inst_i[31:25] == 7'b0100000);
    end
  endgenerate

  // Opcode/funct decode into ALU op, operand selects and immediate format.
  always_comb begin
    w_op   = ALU_NONE;
    w_fmt  = IMM_NONE;
    w_bimm = 1'b0;
    w_apc  = 1'b0;
    w_ill  = 1'b0;
    w_md   = 1'b0;
    case (w_opc)
      OPC_OP_IMM: begin
        w_bimm = 1'b1;
        w_fmt  = IMM_I;
        case (w_f3)
          3'b001: begin
            if (w_sh_zero) w_op = ALU_SLL;
            else           w_ill = 1'b1;
          end
          3'b101: begin
            if (w_sh_zero)     w_op = ALU_SRL;
            else if (w_sh_sra) w_op = ALU_SRA;
            else               w_ill = 1'b1;
          end
          default: w_op = alu_from_f3(w_f3);
        endcase
      end
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          w_op = alu_from_f3(w_f3);
        end else if (w_f7 == F7_ALT) begin
          case (w_f3)
            3'b000:  w_op  = ALU_SUB;
            3'b101:  w_op  = ALU_SRA;
            default: w_ill = 1'b1;
          endcase
        end else if (w_f7 == F7_MULDIV) begin
`ifdef MEXT_EN
          w_md = 1'b1;
`else
          w_ill = 1'b1;
`endif
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_LUI: begin
        w_op   = ALU_PASSB;
        w_bimm = 1'b1;
        w_fmt  = IMM_U;
      end
      OPC_AUIPC: begin
        w_op   = ALU_ADD;
        w_apc  = 1'b1;
        w_bimm = 1'b1;
        w_fmt  = IMM_U;
      end
      OPC_JAL: begin
        w_op   = ALU_ADD;
        w_apc  = 1'b1;
        w_bimm = 1'b1;
        w_fmt  = IMM_J;
      end
      OPC_JALR: begin
        w_fmt = IMM_I;
        if (w_f3 == 3'b000) begin
          w_op   = ALU_ADD;
          w_bimm = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        w_fmt = IMM_I;
        case (w_f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            w_op   = ALU_ADD;
            w_bimm = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_fmt = IMM_S;
        if (w_f3 <= 3'b010) begin
          w_op   = ALU_ADD;
          w_bimm = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_BRANCH: begin
        w_fmt = IMM_B;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
        else                                   w_op  = ALU_SUB;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        w_op = ALU_NONE;
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Illegal instructions carry no operation and no operand selects.
  always_comb begin
    dec_o         = '0;
    dec_o.alu_op  = w_ill ? ALU_NONE : w_op;
    dec_o.b_imm   = w_bimm & ~w_ill;
    dec_o.a_pc    = w_apc & ~w_ill;
    dec_o.imm     = imm_gen(inst_i, w_fmt);
    dec_o.illegal = w_ill;
    dec_o.pc      = XLEN_MAX'(pc_i);
    dec_o.md_sel  = w_md;
    dec_o.md_op   = w_f3;
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pipe
// Description : Registered ALU control decoder behind a valid/ready handshake
//               with a 2-entry skid buffer and a saturating illegal counter.
//               Define MEXT_EN to add out_md_op/out_md_sel and decode mul/div.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_alu_op,
  output logic             out_b_imm,
  output logic             out_a_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
`ifdef MEXT_EN
  output logic [2:0]       out_md_op,
  output logic             out_md_sel,
`endif
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_t             w_dec;
  logic             w_accept;
  logic             w_drain;
  logic             w_unused_bits;

  dec_t             out_q,       out_d;
  logic             out_valid_q, out_valid_d;
  dec_t             skid_q,      skid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  alu_ctrl_dec #(.XLEN(XLEN)) u_dec (
    .inst_i (in_inst),
    .pc_i   (in_pc),
    .dec_o  (w_dec)
  );

  assign in_ready = ~skid_valid_q;
  assign w_accept = in_valid & ~skid_valid_q;
  assign w_drain  = out_valid_q & out_ready;

  // Next-state for output/skid entries and the saturating illegal counter.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (skid_valid_q) begin
      // in_ready is low, so the only movement is skid -> output on drain.
      if (w_drain) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (!out_valid_q || w_drain) begin
        out_d       = w_dec;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = w_dec;
        skid_valid_d = 1'b1;
      end
    end else if (w_drain) begin
      out_valid_d = 1'b0;
    end
    if (w_accept && w_dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset drops any in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc[XLEN-1:0];
  assign out_alu_op  = out_q.alu_op;
  assign out_b_imm   = out_q.b_imm;
  assign out_a_pc    = out_q.a_pc;
  assign out_imm     = out_q.imm[XLEN-1:0];
  assign out_illegal = out_q.illegal;
  assign illegal_cnt = cnt_q;
`ifdef MEXT_EN
  assign out_md_op   = out_q.md_op;
  assign out_md_sel  = out_q.md_sel;
`endif

  // Upper datapath bits (narrow XLEN) and md fields (no MEXT_EN) go unused.
  assign w_unused_bits = ^out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_pipe
// Description : Self-checking bench for alu_ctrl_pipe: directed cases plus
//               random traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_pipe;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [3:0]       out_alu_op;
  logic             out_b_imm;
  logic             out_a_pc;
  logic [XLEN-1:0]  out_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;
`ifdef MEXT_EN
  logic [2:0]       out_md_op;
  logic             out_md_sel;
`endif

  alu_ctrl_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_alu_op  (out_alu_op),
    .out_b_imm   (out_b_imm),
    .out_a_pc    (out_a_pc),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
`ifdef MEXT_EN
    .out_md_op   (out_md_op),
    .out_md_sel  (out_md_sel),
`endif
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu_op;
    logic        b_imm;
    logic        a_pc;
    logic        illegal;
    logic        chk_imm;
    logic        md_sel;
    logic [2:0]  md_op;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  int unsigned exp_cnt;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [31:0] sext(input int unsigned v, input int bits);
    int unsigned m = 32'd1 << bits;
    if (v >= (m >> 1)) return v - m;
    return v;
  endfunction

  // Reference decode computed field by field with integer arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    int unsigned f   = w;
    int unsigned opc = f & 127;
    int unsigned f3  = (f >> 12) & 7;
    int unsigned f7  = f >> 25;
    logic [31:0] iimm = sext(f >> 20, 12);
    logic [31:0] simm = sext(((f >> 25) << 5) | ((f >> 7) & 31), 12);
    logic [31:0] bimm = sext(((f >> 31) << 12) | (((f >> 7) & 1) << 11) |
                             (((f >> 25) & 63) << 5) | (((f >> 8) & 15) << 1), 13);
    logic [31:0] jimm = sext(((f >> 31) << 20) | (((f >> 12) & 255) << 12) |
                             (((f >> 20) & 1) << 11) | (((f >> 21) & 1023) << 1), 21);
    logic [31:0] uimm = f & 32'hFFFFF000;
    e = '{alu_op: 4'hF, b_imm: 0, a_pc: 0, illegal: 0, chk_imm: 0,
          md_sel: 0, md_op: f3[2:0], imm: 0, pc: pc};
    case (opc)
      'h13: begin
        e.b_imm = 1; e.chk_imm = 1; e.imm = iimm;
        if (f3 == 1) begin
          if (f7 == 0) e.alu_op = 4'd1; else e.illegal = 1;
        end else if (f3 == 5) begin
          if (f7 == 0) e.alu_op = 4'd5;
          else if (f7 == 'h20) e.alu_op = 4'd13;
          else e.illegal = 1;
        end else e.alu_op = f3[3:0];
      end
      'h33: begin
        if (f7 == 0) e.alu_op = f3[3:0];
        else if (f7 == 'h20 && f3 == 0) e.alu_op = 4'd8;
        else if (f7 == 'h20 && f3 == 5) e.alu_op = 4'd13;
`ifdef MEXT_EN
        else if (f7 == 1) e.md_sel = 1;
`endif
        else e.illegal = 1;
      end
      'h37: begin e.alu_op = 4'd9; e.b_imm = 1; e.chk_imm = 1; e.imm = uimm; end
      'h17: begin e.alu_op = 0; e.b_imm = 1; e.a_pc = 1; e.chk_imm = 1; e.imm = uimm; end
      'h6F: begin e.alu_op = 0; e.b_imm = 1; e.a_pc = 1; e.chk_imm = 1; e.imm = jimm; end
      'h67: begin
        if (f3 == 0) begin e.alu_op = 0; e.b_imm = 1; e.chk_imm = 1; e.imm = iimm; end
        else e.illegal = 1;
      end
      'h03: begin
        if (f3 == 3 || f3 > 5) e.illegal = 1;
        else begin e.alu_op = 0; e.b_imm = 1; e.chk_imm = 1; e.imm = iimm; end
      end
      'h23: begin
        if (f3 > 2) e.illegal = 1;
        else begin e.alu_op = 0; e.b_imm = 1; e.chk_imm = 1; e.imm = simm; end
      end
      'h63: begin
        if (f3 == 2 || f3 == 3) e.illegal = 1;
        else begin e.alu_op = 4'd8; e.chk_imm = 1; e.imm = bimm; end
      end
      'h0F, 'h73: e.alu_op = 4'hF;
      default: e.illegal = 1;
    endcase
    if (e.illegal) e.alu_op = 4'hF;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    int unsigned opcs[11] = '{'h13, 'h33, 'h37, 'h17, 'h6F, 'h67, 'h03, 'h23, 'h63, 'h0F, 'h73};
    int unsigned r   = $urandom();
    int unsigned sel = $urandom_range(0, 13);
    int unsigned f7;
    if (sel > 10) return r;
    case ($urandom_range(0, 3))
      0:       f7 = 0;
      1:       f7 = 'h20;
      2:       f7 = 1;
      default: f7 = r >> 25;
    endcase
    return (f7 << 25) | (r & 32'h01FFFF80) | opcs[sel];
  endfunction

  // One clock: check outputs against the model, drive inputs, update model.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic rdy);
    exp_t        e;
    logic        acc;
    logic        drn;
    logic [31:0] pc = $urandom();
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    check("illegal_cnt", illegal_cnt, exp_cnt);
    if (out_valid && q.size() > 0) begin
      e = q[0];
      check("out_pc", out_pc, e.pc);
      check("out_alu_op", out_alu_op, e.alu_op);
      check("out_illegal", out_illegal, e.illegal);
      if (!e.illegal) begin
        check("out_b_imm", out_b_imm, e.b_imm);
        check("out_a_pc", out_a_pc, e.a_pc);
        if (e.chk_imm) check("out_imm", out_imm, e.imm);
`ifdef MEXT_EN
        check("out_md_sel", out_md_sel, e.md_sel);
        if (e.md_sel) check("out_md_op", out_md_op, e.md_op);
`endif
      end
    end
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    acc = v && in_ready;
    drn = out_valid && rdy;
    if (drn && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      e = model(inst, pc);
      q.push_back(e);
      if (e.illegal && exp_cnt < (32'd1 << CNT_W) - 1) exp_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] bp[3];
    n_checks = 0;
    n_pass   = 0;
    exp_cnt  = 0;
    bp[0] = 32'h003100B3; bp[1] = 32'h00314133; bp[2] = 32'h0041E1B3;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cnt", illegal_cnt, 0);
    check("rst_alu_op", out_alu_op, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Throughput: add then sub back to back
    cycle(1, 32'h003100B3, 1);
    cycle(1, 32'h403100B3, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // Backpressure: three cycles stalled while streaming, then release
    for (int i = 0; i < 3; i++) cycle(1, bp[i], 0);
    check("bp_in_ready", in_ready, 0);
    cycle(1, bp[2], 1);
    cycle(1, bp[2], 1);
    repeat (3) cycle(0, 0, 1);

    // Immediates and operand selects
    cycle(1, 32'h40315093, 1);  // srai x1,x2,3
    cycle(1, 32'hFFFFF0B7, 1);  // lui x1,0xFFFFF
    cycle(1, 32'h008000EF, 1);  // jal x1,8
    cycle(1, 32'hFE208EE3, 1);  // beq backward
    cycle(0, 0, 1);

    // Illegal: sll with funct7=0100000, five times saturates a 2-bit counter
    for (int i = 0; i < 5; i++) cycle(1, 32'h403110B3, 1);
    cycle(0, 0, 1);
    check("cnt_saturated", illegal_cnt, 3);

    // mul: md_sel with MEXT_EN, illegal otherwise
    cycle(1, 32'h023100B3, 1);
    cycle(0, 0, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);

    // Reset mid-stream with the skid entry full
    for (int i = 0; i < 8 && in_ready; i++) cycle(1, rand_inst(), 0);
    check("pre_rst_skid_full", in_ready, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_cnt", illegal_cnt, 0);
    check("mid_rst_imm", out_imm, 0);
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 1) != 0, rand_inst(), $urandom_range(0, 1) != 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
Registered, parametrised successor to the combinational ALU control decoder. It sits between fetch and execute in mp_pipeline. It decodes a 32-bit RV instruction into ALU control, operand-select, immediate and illegal-instruction flags, and registers the result behind a valid/ready handshake with a 2-entry skid buffer. This gives full throughput with a registered in_ready. A saturating illegal-instruction counter is included.

Parameters:
XLEN, 32, datapath width (32 or 64); sets the pc/imm width and the shamt width (5 or 6 bits).
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept; registered, equals !skid_valid
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction pc, passed through
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  registered pc
out_alu_op  out  4  0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1000 sub, 1001 pass-B, 1101 sra, 1111 none
out_b_imm  out  1  operand B is the immediate
out_a_pc  out  1  operand A is pc (auipc, jal)
out_imm  out  XLEN  sign-extended I/S/B/U/J immediate
out_illegal  out  1  undecodable instruction
illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (async assert, sync deassert): out_valid=0, skid_valid=0, in_ready=1, all data outputs 0, illegal_cnt=0. Reset mid-transfer drops both entries.
- Transfer on in_valid&&in_ready, or on out_valid&&out_ready. Latency: an accepted instruction appears on out_* the next cycle.
- Data-path entries:
  - Output register: decoded from in_inst when accepted, or loaded from the skid register.
  - Skid register: holds one decoded entry.
- Output register update rules:
  - Output empty, or draining this cycle, with skid empty: accept goes directly to the output register.
  - Output full, not draining, and accept: entry goes to skid; skid_valid=1, so in_ready=0 next cycle.
  - Output draining while skid full: skid moves to output; skid_valid=0.
  - Simultaneous accept and drain with output full and skid empty: the new entry replaces the output; out_valid stays 1.
- Output stability: out_* remain stable while out_valid && !out_ready.
- Decode, opcode 0010011 (OP-IMM):
  - funct3 000→add, 010→slt, 011→sltu, 100→xor, 110→or, 111→and.
  - 001→sll, only if the upper funct bits are zero.
  - 101→srl if the upper bits are 0, sra if 0100000; any other value is illegal.
  - The upper-bit check uses funct7 when XLEN=32 and funct6 when XLEN=64.
- Decode, opcode 0110011 (OP):
  - funct7=0000000: funct3 maps as for OP-IMM.
  - funct7=0100000: funct3 000→sub, 101→sra.
  - Anything else is illegal.
- Decode, other opcodes:
  - 0110111 lui→pass-B.
  - 0010111 auipc→add with a_pc.
  - 1101111 jal→add with a_pc.
  - 1100111 jalr (funct3=000)→add.
  - 0000011 load (funct3 ∈ 000,001,010,100,101)→add.
  - 0100011 store (funct3 000..010)→add.
  - 1100011 branch (funct3 ≠ 010/011)→sub.
  - 0001111, 1110011 → alu_op none, not illegal.
  - Everything else → illegal, alu_op=1111.
- Immediates: I/S/B/U/J formats, sign-extended to XLEN; U-format places the 20 bits at [31:12] and sign-extends for XLEN=64.
- illegal_cnt increments on accept of an illegal instruction and saturates at all-ones.

Optional Feature:
MEXT_EN.
- Defined: adds port out_md_op (3 bits, the funct3 value) and out_md_sel (1 bit). OP with funct7=0000001 decodes as legal, with out_md_sel=1 and out_alu_op=1111.
- Undefined: those ports are absent, and funct7=0000001 is illegal.

Decomposition:
Shared package alu_ctrl_pkg:
- alu_op_t enum with the encodings above.
- Opcode localparams.
- imm_fmt_t.
- Decoded struct dec_t holding the alu_op, b_imm, a_pc, imm, illegal, pc and md fields.

One sub-module, alu_ctrl_dec: purely combinational, inst/pc → dec_t. The top-level module is the skid buffer plus the counter.

Test Plan:
- Reset: rst_n=0 mid-stream with skid full → out_valid=0, in_ready=1, illegal_cnt=0 immediately.
- Throughput: back-to-back add x1,x2,x3 (0x003100B3) then sub (0x403100B3), out_ready=1 → out_alu_op 0000 then 1000 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles while streaming → one entry held in skid, in_ready=0, no loss or duplication; ordering preserved after release.
- Immediates: srai x1,x2,3 (0x40315093) → alu_op 1101, b_imm=1. lui 0xFFFFF → imm=0xFFFFF000. jal → a_pc=1.
- Illegal handling: OP with funct7=0100000, funct3=001 → out_illegal=1, illegal_cnt+1. With CNT_W=2, 5 illegal instructions → illegal_cnt=3.
- MEXT_EN: mul (0x023100B3) → md_sel=1, md_op=000. Without the macro → illegal=1.
